// File: rtl/bg_sequencer.sv
// bg_sequencer: frame-ticked single-channel ramp/hold background colour sequencer with a
// config handshake accepted only in IDLE and HOLD_LO.
module bg_sequencer #(
    parameter logic [3:0] STEP_DEFAULT = 4'd1,
    parameter logic [7:0] HOLD_DEFAULT = 8'd30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_step,
    input  logic [7:0]  cfg_hold,
    input  logic [1:0]  cfg_chan,
    input  logic        freeze,
    output logic [23:0] pixel,
    output logic [1:0]  chan,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {IDLE = 3'd0, RAMP_UP = 3'd1, HOLD_HI = 3'd2, RAMP_DOWN = 3'd3, HOLD_LO = 3'd4} state_t;

    state_t      state_q, state_d;
    logic [7:0]  lvl_q, lvl_d, cnt_q, cnt_d, hold_q, hold_d;
    logic [3:0]  step_q, step_d;
    logic [1:0]  chan_q, chan_d;
    logic        vs_q;
    logic        tick, xfer;
    logic [8:0]  stp, sum, diff;

    assign tick      = vsync & ~vs_q & ~freeze;
    assign cfg_ready = (state_q == IDLE) || (state_q == HOLD_LO);
    assign xfer      = cfg_valid & cfg_ready;
    assign stp       = {5'd0, (step_q == 4'd0) ? 4'd1 : step_q};
    assign sum       = {1'b0, lvl_q} + stp;
    assign diff      = {1'b0, lvl_q} - stp;
    assign pixel     = {(chan_q == 2'd0) ? lvl_q : 8'h00,
                        (chan_q == 2'd1) ? lvl_q : 8'h00,
                        (chan_q == 2'd2) ? lvl_q : 8'h00};
    assign chan      = chan_q;
    assign state     = state_q;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        step_d  = step_q;
        hold_d  = hold_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    lvl_d   = stp[7:0];
                    state_d = RAMP_UP;
                end
                RAMP_UP: begin
                    lvl_d = (sum >= 9'd255) ? 8'd255 : sum[7:0];
                    if (sum >= 9'd255) begin
                        cnt_d   = hold_q;
                        state_d = HOLD_HI;
                    end
                end
                HOLD_HI: begin
                    state_d = (cnt_q == 8'd0) ? RAMP_DOWN : HOLD_HI;
                    cnt_d   = (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
                end
                RAMP_DOWN: begin
                    lvl_d = (diff[8] || diff == 9'd0) ? 8'd0 : diff[7:0];
                    if (diff[8] || diff == 9'd0) begin
                        cnt_d   = hold_q;
                        state_d = HOLD_LO;
                    end
                end
                HOLD_LO: begin
                    state_d = (cnt_q == 8'd0) ? RAMP_UP : HOLD_LO;
                    cnt_d   = (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
                    chan_d  = (cnt_q != 8'd0) ? chan_q : (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;
                end
                default: state_d = IDLE;
            endcase
        end
        // The tick above already used the old step/hold; the transfer only updates them.
        if (xfer) begin
            step_d = cfg_step;
            hold_d = cfg_hold;
            if (state_q == IDLE) chan_d = (cfg_chan == 2'd3) ? 2'd0 : cfg_chan;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lvl_q   <= 8'd0;
            cnt_q   <= 8'd0;
            chan_q  <= 2'd0;
            step_q  <= STEP_DEFAULT;
            hold_q  <= HOLD_DEFAULT;
            vs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            vs_q    <= vsync;
        end
    end
endmodule
